// File: rtl/id_front.sv
// ID-stage front end: pipeline register, register-field extraction,
// load-use replay towards fetch and wrong-path invalidation after redirects.
module id_front #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_Instr,
    input  logic [31:0]      IF_Pc,
    input  logic [31:0]      IF_Pc4,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             ex_redirect,
    output logic [31:0]      ID_Instr,
    output logic [31:0]      ID_Pc,
    output logic [31:0]      ID_Pc4,
    output logic [4:0]       ID_Rs1,
    output logic [4:0]       ID_Rs2,
    output logic [4:0]       ID_Rd,
    output logic             ID_Issue,
    output logic             StallPc,
    output logic [31:0]      Pc_update,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        REPLAY,
        FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic       vld, vld_nxt;
    logic       load_id, stall_inc, flush_inc;
    logic       uses_rs1, uses_rs2, hazard;
    logic [6:0] opcode;

    assign ID_Rs1    = ID_Instr[19:15];
    assign ID_Rs2    = ID_Instr[24:20];
    assign ID_Rd     = ID_Instr[11:7];
    assign opcode    = ID_Instr[6:0];
    assign Pc_update = IF_Pc;

    always_comb begin
        uses_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 ||
                     opcode == 7'b1101111);
        uses_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 ||
                    opcode == 7'b1100011);
        hazard = (state == RUN) && vld && EX_MemRead && (EX_Rd != 5'd0) &&
                 ((uses_rs1 && ID_Rs1 == EX_Rd) ||
                  (uses_rs2 && ID_Rs2 == EX_Rd));
        ID_Issue = vld && !hazard && !ex_redirect && (state != FLUSH);
        StallPc  = hazard && !ex_redirect;
    end

    always_comb begin
        state_nxt = state;
        vld_nxt   = vld;
        load_id   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (ex_redirect) begin
            state_nxt = FLUSH;
            vld_nxt   = 1'b0;
            flush_inc = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        state_nxt = REPLAY;
                        stall_inc = 1'b1;
                    end else begin
                        load_id = 1'b1;
                        vld_nxt = 1'b1;
                    end
                end
                // IF holds a garbage or wrong-path value in both cases.
                REPLAY, FLUSH: begin
                    state_nxt = RUN;
                    vld_nxt   = 1'b0;
                end
                default: begin
                    state_nxt = FLUSH;
                    vld_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FLUSH;
            vld       <= 1'b0;
            ID_Instr  <= '0;
            ID_Pc     <= '0;
            ID_Pc4    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            vld   <= vld_nxt;
            if (load_id) begin
                ID_Instr <= IF_Instr;
                ID_Pc    <= IF_Pc;
                ID_Pc4   <= IF_Pc4;
            end
            if (stall_inc && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_front.sv
// Bench for id_front: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_id_front;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [6:0] OPS [9] = '{
        7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
        7'b1101111, 7'b0000011, 7'b0010011, 7'b1100111
    };

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   IF_Instr, IF_Pc, IF_Pc4;
    logic          EX_MemRead;
    logic [4:0]    EX_Rd;
    logic          ex_redirect;
    logic [31:0]   ID_Instr, ID_Pc, ID_Pc4, Pc_update;
    logic [4:0]    ID_Rs1, ID_Rs2, ID_Rd;
    logic          ID_Issue, StallPc;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    id_front #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_Instr(IF_Instr), .IF_Pc(IF_Pc), .IF_Pc4(IF_Pc4),
        .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .ex_redirect(ex_redirect),
        .ID_Instr(ID_Instr), .ID_Pc(ID_Pc), .ID_Pc4(ID_Pc4),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
        .ID_Issue(ID_Issue), .StallPc(StallPc), .Pc_update(Pc_update),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic bit reads1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit reads2(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    // Model: a valid flag, the held instruction, and a flag saying the
    // next capture from IF must be thrown away (after stall or redirect).
    bit          m_vld  = 1'b0;
    bit          m_drop = 1'b1;
    logic [31:0] m_instr = '0, m_pc = '0, m_pc4 = '0;
    int          m_stall = 0, m_flush = 0;

    always @(negedge clk) begin
        bit haz, iss, stl;
        if (!rst) begin
            m_vld = 1'b0; m_drop = 1'b1;
            m_instr = '0; m_pc = '0; m_pc4 = '0;
            m_stall = 0; m_flush = 0;
        end
        haz = !m_drop && m_vld && EX_MemRead && EX_Rd != 5'd0 &&
              ((reads1(m_instr[6:0]) && m_instr[19:15] == EX_Rd) ||
               (reads2(m_instr[6:0]) && m_instr[24:20] == EX_Rd));
        iss = m_vld && !haz && !ex_redirect;
        stl = haz && !ex_redirect;
        chk("m_instr", ID_Instr, m_instr);
        chk("m_pc", ID_Pc, m_pc);
        chk("m_pc4", ID_Pc4, m_pc4);
        chk("m_rs1", 32'(ID_Rs1), 32'(m_instr[19:15]));
        chk("m_rs2", 32'(ID_Rs2), 32'(m_instr[24:20]));
        chk("m_rd", 32'(ID_Rd), 32'(m_instr[11:7]));
        chk("m_issue", 32'(ID_Issue), 32'(iss));
        chk("m_stallpc", 32'(StallPc), 32'(stl));
        chk("m_pcupd", Pc_update, IF_Pc);
        chk("m_scnt", 32'(stall_cnt), 32'(m_stall));
        chk("m_fcnt", 32'(flush_cnt), 32'(m_flush));
        if (rst) begin
            if (ex_redirect) begin
                m_vld = 1'b0; m_drop = 1'b1;
                if (m_flush < CMAX) m_flush++;
            end else if (m_drop) begin
                m_vld = 1'b0; m_drop = 1'b0;
            end else if (haz) begin
                m_drop = 1'b1;
                if (m_stall < CMAX) m_stall++;
            end else begin
                m_instr = IF_Instr; m_pc = IF_Pc; m_pc4 = IF_Pc4;
                m_vld = 1'b1;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [31:0] ins, input logic [31:0] pc);
        IF_Instr = ins; IF_Pc = pc; IF_Pc4 = pc + 32'd4;
    endtask

    task automatic ex_set(input logic mr, input logic [4:0] rd,
                          input logic rdir);
        EX_MemRead = mr; EX_Rd = rd; ex_redirect = rdir;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] op;
        op = OPS[$urandom_range(0, 8)];
        return {7'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        rst = 1'b1;
        set_if(32'h0, 32'h0);
        ex_set(1'b0, 5'd0, 1'b0);
        #2 rst = 1'b0;
        cyc; cyc; #1;
        chk("rst_issue", 32'(ID_Issue), 32'd0);
        chk("rst_stallpc", 32'(StallPc), 32'd0);
        chk("rst_pc", ID_Pc, 32'd0);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        cyc; rst = 1'b1; set_if(32'hdeadbeef, 32'hffc);
        cyc; set_if(32'h00000013, 32'h0); #1;
        chk("boot_drop", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'h00100093, 32'h4); #1;
        chk("boot_pc", ID_Pc, 32'h0);
        chk("boot_issue", 32'(ID_Issue), 32'd1);
        chk("boot_pc4", ID_Pc4, 32'h4);
        cyc; set_if(32'h00208033, 32'h1c);
        cyc; set_if(32'h00000013, 32'h20); ex_set(1'b1, 5'd2, 1'b0); #1;
        chk("lu_stallpc", 32'(StallPc), 32'd1);
        chk("lu_pcupd", Pc_update, 32'h20);
        chk("lu_issue0", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'hbad0bad0, 32'h99c); #1;
        chk("lu_masked", 32'(StallPc), 32'd0);
        chk("lu_issue1", 32'(ID_Issue), 32'd1);
        chk("lu_instr", ID_Instr, 32'h00208033);
        chk("lu_scnt", 32'(stall_cnt), 32'd1);
        cyc; set_if(32'h00000013, 32'h20); ex_set(1'b0, 5'd0, 1'b0); #1;
        chk("lu_issue2", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'h000010b7, 32'h24); #1;
        chk("lu_y_pc", ID_Pc, 32'h20);
        chk("lu_y_issue", 32'(ID_Issue), 32'd1);
        cyc; set_if(32'h00208033, 32'h28); ex_set(1'b1, 5'd1, 1'b0); #1;
        chk("lui_nostall", 32'(StallPc), 32'd0);
        chk("lui_issue", 32'(ID_Issue), 32'd1);
        cyc; set_if(32'h00000013, 32'h2c); ex_set(1'b1, 5'd0, 1'b0); #1;
        chk("x0_nostall", 32'(StallPc), 32'd0);
        chk("x0_issue", 32'(ID_Issue), 32'd1);
        cyc; set_if(32'h00000013, 32'h30); ex_set(1'b0, 5'd0, 1'b1); #1;
        chk("br_t0", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'h00000013, 32'h34); ex_set(1'b0, 5'd0, 1'b0); #1;
        chk("br_t1", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'h00100093, 32'h80); #1;
        chk("br_t2", 32'(ID_Issue), 32'd0);
        cyc; set_if(32'h00208033, 32'h84); #1;
        chk("br_pc", ID_Pc, 32'h80);
        chk("br_issue", 32'(ID_Issue), 32'd1);
        chk("br_fcnt", 32'(flush_cnt), 32'd1);
        cyc; set_if(32'h00000013, 32'h88); ex_set(1'b1, 5'd2, 1'b1); #1;
        chk("both_stallpc", 32'(StallPc), 32'd0);
        chk("both_issue", 32'(ID_Issue), 32'd0);
        cyc; ex_set(1'b0, 5'd0, 1'b0); #1;
        chk("both_scnt", 32'(stall_cnt), 32'd1);
        chk("both_fcnt", 32'(flush_cnt), 32'd2);
        cyc; set_if(32'h00000013, 32'h90); #1;
        chk("both_drop", 32'(ID_Issue), 32'd0);
        cyc; #1;
        chk("both_pc", ID_Pc, 32'h90);
        for (int i = 0; i < 4; i++) begin
            cyc; set_if(32'h00208033, 32'h100 + 32'(16 * i));
            ex_set(1'b0, 5'd0, 1'b0);
            cyc; ex_set(1'b1, 5'd1, 1'b0);
            cyc; ex_set(1'b0, 5'd0, 1'b0);
            cyc;
        end
        #1 chk("sat_scnt", 32'(stall_cnt), 32'd3);
        cyc; ex_set(1'b1, 5'd1, 1'b0); #1;
        chk("sat_stallpc", 32'(StallPc), 32'd1);
        cyc; ex_set(1'b0, 5'd0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("arst_instr", ID_Instr, 32'd0);
        chk("arst_pc", ID_Pc, 32'd0);
        chk("arst_pc4", ID_Pc4, 32'd0);
        chk("arst_issue", 32'(ID_Issue), 32'd0);
        chk("arst_stallpc", 32'(StallPc), 32'd0);
        chk("arst_scnt", 32'(stall_cnt), 32'd0);
        chk("arst_fcnt", 32'(flush_cnt), 32'd0);
        cyc; cyc; rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc;
            rst = ($urandom_range(0, 199) != 0);
            set_if(rnd_instr(), {22'($urandom_range(0, 255)), 2'b00, 8'h0});
            ex_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0);
        end
        cyc; rst = 1'b1; ex_set(1'b0, 5'd0, 1'b0);
        cyc; cyc;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
